expr_reuse_sched: RTL and testbench
===================================

Name: expr_reuse_sched

Overview:
- Shares one pipelined bitwise-op unit (AND/OR/XOR/ANDN) between NREQ requesters.
- Keeps a small result cache keyed by (op, a, b), so a redundant expression already computed returns without re-issuing. This is the hardware analogue of value-number reuse across phi branches.
- Sits between expression-producing datapath slices and the shared logic unit. Round-robin arbitration; one operation in flight.

Parameters:
- W, 8, operand/result width
- NREQ, 2, number of requesters
- NENT, 4, cache entries, fully associative, power of 2
- LAT, 2, shared unit latency in cycles, ≥1

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- req_valid  in  NREQ  request valid per requester
- req_ready  out  NREQ  request accepted (one-hot or zero)
- req_op  in  2*NREQ  op per requester: 00 AND, 01 OR, 10 XOR, 11 ANDN (a & ~b)
- req_a  in  W*NREQ  operand a per requester
- req_b  in  W*NREQ  operand b per requester
- rsp_valid  out  NREQ  one-cycle response pulse to the originating requester
- rsp_data  out  W*NREQ  result; valid only with rsp_valid
- rsp_hit  out  NREQ  response came from cache
- flush  in  1  invalidate all cache entries
- hit_count  out  16  saturating count of cache hits

Behaviour:
- Reset (reset_n=0 at posedge):
  - state IDLE; all cache valid bits 0; RR pointer 0; FIFO replace pointer 0.
  - rsp_valid, rsp_hit, rsp_data 0; hit_count 0.
  - req_ready 0 while reset_n=0.
- FSM states: IDLE, EXEC, RESP.
- Arbitration (IDLE only):
  - Grant the first valid requester at or after the RR pointer.
  - req_ready[g] = req_valid[g] & grant[g] & (state==IDLE). Combinational; no other ready bit is high.
  - Handshake = valid & ready. On handshake the RR pointer becomes g+1 mod NREQ. Requesters hold op/a/b stable until ready.
- Key normalisation:
  - AND, OR and XOR are commutative: the key stores (min(a,b), max(a,b)).
  - ANDN is stored unswapped.
  - Key = {op, a', b'}.
- Lookup is combinational in the handshake cycle, compared against all valid entries.
  - Hit: capture data and requester id, go to RESP. At t+1: rsp_valid[g]=1, rsp_hit[g]=1, hit_count++ (saturates at 0xFFFF).
  - Miss: issue to the unit, go to EXEC for LAT cycles (down-counter). At completion go to RESP. At t+1+LAT: rsp_valid[g]=1, rsp_hit[g]=0.
  - In the same RESP cycle, write the result into the entry at the FIFO pointer and increment the pointer mod NENT.
- RESP lasts exactly one cycle, then IDLE. A new handshake is possible in the cycle after RESP.
  - Throughput: hit, 1 op per 2 cycles; miss, 1 op per LAT+2 cycles.
- Responses have no backpressure. rsp_data of non-responding requesters is 0.
- Flush:
  - All valid bits clear at the next edge.
  - Flush in the handshake cycle: the lookup still uses pre-flush contents.
  - Flush coincident with a RESP fill: flush wins, no entry is written, but the response is still delivered.
  - Flush during EXEC: the result is still returned, and the fill is suppressed only if flush coincides with RESP.
- Duplicate keys are never created: the key was a miss and only one operation is in flight.
- Reset mid-EXEC or mid-RESP: operation abandoned, no response, state as at reset.
- req_valid deasserting without a handshake is legal and has no effect.

Test Plan:
- Reset, then req0 op=OR a=0x0F b=0xF0 -> req_ready[0]=1 at t; rsp_valid[0]=1, rsp_data=0xFF, rsp_hit=0 at t+3 (LAT=2); hit_count=0.
- Same expression from req1 as OR a=0xF0 b=0x0F (swapped) -> rsp at t+1, rsp_data=0xFF, rsp_hit[1]=1, hit_count=1.
- req0 and req1 valid continuously from reset with distinct ANDN keys (0xFF,0x0F) and (0xFF,0xF0) -> grants alternate 0,1,0; responses 0xF0 and 0x0F to the correct ports; req_ready never two-hot.
- Issue 5 distinct misses with NENT=4, then repeat the first key -> first key evicted, so miss (latency LAT+1); the 2nd key still hits.
- Fill XOR 0xAA,0x55 (=0xFF), then assert flush together with a new miss's RESP cycle -> response delivered; both keys subsequently miss.
- Assert reset_n=0 during EXEC -> no rsp_valid pulse; after release the cache is empty and the RR pointer restarts at requester 0.

Source files
------------

// File: rtl/expr_reuse_sched.sv
// expr_reuse_sched: shares one pipelined bitwise-op unit between NREQ requesters.
// A small fully associative cache keyed by the normalised expression (op, a, b)
// answers redundant expressions without re-issuing them to the unit.
module expr_reuse_sched #(
  parameter int W    = 8,
  parameter int NREQ = 2,
  parameter int NENT = 4,
  parameter int LAT  = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [2*NREQ-1:0] req_op,
  input  logic [W*NREQ-1:0] req_a,
  input  logic [W*NREQ-1:0] req_b,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [W*NREQ-1:0] rsp_data,
  output logic [NREQ-1:0]   rsp_hit,
  input  logic              flush,
  output logic [15:0]       hit_count
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int EW = (NENT > 1) ? $clog2(NENT) : 1;
  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_EXEC = 2'd1, ST_RESP = 2'd2} state_t;

  // Shared logic unit function: 00 AND, 01 OR, 10 XOR, 11 ANDN (a & ~b).
  function automatic logic [W-1:0] alu_f(input logic [1:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    logic [W-1:0] r;
    case (op)
      2'b00:   r = a & b;
      2'b01:   r = a | b;
      2'b10:   r = a ^ b;
      2'b11:   r = a & ~b;
      default: r = {W{1'b0}};
    endcase
    return r;
  endfunction

  state_t            state_r;
  logic [IW-1:0]     rr_r;
  logic [IW-1:0]     id_r;
  logic [EW-1:0]     fifo_r;
  logic [CW-1:0]     cnt_r;
  logic              fill_pend_r;
  logic [1:0]        key_op_r;
  logic [W-1:0]      key_a_r;
  logic [W-1:0]      key_b_r;
  logic [W-1:0]      res_r;
  logic [W-1:0]      res_pipe_r [LAT];
  logic [NENT-1:0]   ent_valid_r;
  logic [1:0]        ent_op_r   [NENT];
  logic [W-1:0]      ent_a_r    [NENT];
  logic [W-1:0]      ent_b_r    [NENT];
  logic [W-1:0]      ent_data_r [NENT];
  logic [NREQ-1:0]   rsp_valid_r;
  logic [NREQ-1:0]   rsp_hit_r;
  logic [W*NREQ-1:0] rsp_data_r;
  logic [15:0]       hit_count_r;

  logic              gnt_any_s;
  logic [IW-1:0]     gnt_id_s;
  logic              hs_s;
  logic [NREQ-1:0]   ready_s;
  logic [1:0]        sel_op_s;
  logic [W-1:0]      sel_a_s;
  logic [W-1:0]      sel_b_s;
  logic              swap_s;
  logic [W-1:0]      key_a_s;
  logic [W-1:0]      key_b_s;
  logic              hit_s;
  logic [W-1:0]      hit_data_s;

  // Round-robin search: first valid requester at or after the RR pointer.
  always_comb begin
    int  idx;
    logic take;
    gnt_any_s = 1'b0;
    gnt_id_s  = {IW{1'b0}};
    idx       = 0;
    take      = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      idx       = (int'(rr_r) + i >= NREQ) ? int'(rr_r) + i - NREQ : int'(rr_r) + i;
      take      = !gnt_any_s && req_valid[idx];
      gnt_id_s  = take ? IW'(idx) : gnt_id_s;
      gnt_any_s = gnt_any_s | take;
    end
  end

  assign hs_s = (state_r == ST_IDLE) && reset_n && gnt_any_s;

  // One-hot ready toward the granted requester, only in IDLE.
  always_comb begin
    ready_s           = {NREQ{1'b0}};
    ready_s[gnt_id_s] = hs_s;
  end

  // Select the granted request and normalise commutative operands to (min, max).
  always_comb begin
    sel_op_s = req_op[int'(gnt_id_s)*2 +: 2];
    sel_a_s  = req_a[int'(gnt_id_s)*W +: W];
    sel_b_s  = req_b[int'(gnt_id_s)*W +: W];
    swap_s   = (sel_op_s != 2'b11) && (sel_a_s > sel_b_s);
    key_a_s  = swap_s ? sel_b_s : sel_a_s;
    key_b_s  = swap_s ? sel_a_s : sel_b_s;
  end

  // Associative lookup against all valid entries; keys are unique so OR-merge is safe.
  always_comb begin
    logic m;
    hit_s      = 1'b0;
    hit_data_s = {W{1'b0}};
    m          = 1'b0;
    for (int e = 0; e < NENT; e++) begin
      m          = ent_valid_r[e] && (ent_op_r[e] == sel_op_s) &&
                   (ent_a_r[e] == key_a_s) && (ent_b_r[e] == key_b_s);
      hit_s      = hit_s | m;
      hit_data_s = hit_data_s | (m ? ent_data_r[e] : {W{1'b0}});
    end
  end

  // Scheduler FSM, unit pipeline, cache fill/flush and registered response outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      rr_r        <= {IW{1'b0}};
      id_r        <= {IW{1'b0}};
      fifo_r      <= {EW{1'b0}};
      cnt_r       <= {CW{1'b0}};
      fill_pend_r <= 1'b0;
      key_op_r    <= 2'b00;
      key_a_r     <= {W{1'b0}};
      key_b_r     <= {W{1'b0}};
      res_r       <= {W{1'b0}};
      ent_valid_r <= {NENT{1'b0}};
      rsp_valid_r <= {NREQ{1'b0}};
      rsp_hit_r   <= {NREQ{1'b0}};
      rsp_data_r  <= {(W*NREQ){1'b0}};
      hit_count_r <= 16'h0000;
      for (int k = 0; k < LAT; k++) res_pipe_r[k] <= {W{1'b0}};
      for (int e = 0; e < NENT; e++) begin
        ent_op_r[e]   <= 2'b00;
        ent_a_r[e]    <= {W{1'b0}};
        ent_b_r[e]    <= {W{1'b0}};
        ent_data_r[e] <= {W{1'b0}};
      end
    end else begin
      rsp_valid_r <= {NREQ{1'b0}};
      rsp_hit_r   <= {NREQ{1'b0}};
      rsp_data_r  <= {(W*NREQ){1'b0}};
      for (int k = 1; k < LAT; k++) res_pipe_r[k] <= res_pipe_r[k-1];
      case (state_r)
        ST_IDLE: begin
          if (hs_s) begin
            id_r     <= gnt_id_s;
            key_op_r <= sel_op_s;
            key_a_r  <= key_a_s;
            key_b_r  <= key_b_s;
            rr_r     <= (gnt_id_s == IW'(NREQ - 1)) ? {IW{1'b0}} : gnt_id_s + IW'(1);
            if (hit_s) begin
              state_r                          <= ST_RESP;
              fill_pend_r                      <= 1'b0;
              rsp_valid_r[gnt_id_s]            <= 1'b1;
              rsp_hit_r[gnt_id_s]              <= 1'b1;
              rsp_data_r[int'(gnt_id_s)*W +: W] <= hit_data_s;
              hit_count_r <= (hit_count_r != 16'hFFFF) ? hit_count_r + 16'h0001 : hit_count_r;
            end else begin
              state_r       <= ST_EXEC;
              cnt_r         <= CW'(LAT - 1);
              res_pipe_r[0] <= alu_f(sel_op_s, sel_a_s, sel_b_s);
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_EXEC: begin
          if (cnt_r == {CW{1'b0}}) begin
            state_r                       <= ST_RESP;
            fill_pend_r                   <= 1'b1;
            res_r                         <= res_pipe_r[LAT-1];
            rsp_valid_r[id_r]             <= 1'b1;
            rsp_data_r[int'(id_r)*W +: W] <= res_pipe_r[LAT-1];
          end else begin
            cnt_r <= cnt_r - CW'(1);
          end
        end
        ST_RESP: begin
          state_r     <= ST_IDLE;
          fill_pend_r <= 1'b0;
          if (fill_pend_r && !flush) begin
            ent_valid_r[fifo_r] <= 1'b1;
            ent_op_r[fifo_r]    <= key_op_r;
            ent_a_r[fifo_r]     <= key_a_r;
            ent_b_r[fifo_r]     <= key_b_r;
            ent_data_r[fifo_r]  <= res_r;
            fifo_r <= (fifo_r == EW'(NENT - 1)) ? {EW{1'b0}} : fifo_r + EW'(1);
          end else begin
            fifo_r <= fifo_r;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
      // Flush overrides any fill landing on the same edge.
      if (flush) ent_valid_r <= {NENT{1'b0}};
    end
  end

  assign req_ready = ready_s;
  assign rsp_valid = rsp_valid_r;
  assign rsp_hit   = rsp_hit_r;
  assign rsp_data  = rsp_data_r;
  assign hit_count = hit_count_r;

endmodule

// File: tb/tb_expr_reuse_sched.sv
// Directed self-checking bench for expr_reuse_sched (W=8, NREQ=2, NENT=4, LAT=2).
module tb_expr_reuse_sched;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [3:0]  req_op = 4'h0;
  logic [15:0] req_a = 16'h0000;
  logic [15:0] req_b = 16'h0000;
  logic [1:0]  rsp_valid;
  logic [15:0] rsp_data;
  logic [1:0]  rsp_hit;
  logic        flush = 1'b0;
  logic [15:0] hit_count;

  int n_chk = 0;
  int n_err = 0;

  expr_reuse_sched #(.W(8), .NREQ(2), .NENT(4), .LAT(2)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_hit(rsp_hit), .flush(flush), .hit_count(hit_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Hold reset for two edges with both requesters asking; nothing may be accepted.
  task automatic do_reset();
    @(negedge clk);
    reset_n   = 1'b0;
    flush     = 1'b0;
    req_valid = 2'b11;
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_rspv", 32'(rsp_valid), 32'h0);
    chk("rst_rspd", 32'(rsp_data), 32'h0);
    chk("rst_hitc", 32'(hit_count), 32'h0);
    @(negedge clk);
    req_valid = 2'b00;
    reset_n   = 1'b1;
  endtask

  // One request from requester r; called and returning on a negedge in IDLE.
  task automatic do_op(input string tag, input int r, input logic [1:0] op,
                       input logic [7:0] a, input logic [7:0] b, input int exp_lat,
                       input logic [7:0] exp_d, input logic exp_h, input logic fl);
    int lat;
    req_op[r*2 +: 2] = op;
    req_a[r*8 +: 8]  = a;
    req_b[r*8 +: 8]  = b;
    req_valid[r]     = 1'b1;
    #1;
    chk({tag, "_rdy"}, 32'(req_ready), 32'h1 << r);
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    lat = 1;
    while (rsp_valid == 2'b00 && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_v"}, 32'(rsp_valid), 32'h1 << r);
    chk({tag, "_d"}, 32'(rsp_data), {24'h0, exp_d} << (8 * r));
    chk({tag, "_h"}, 32'(rsp_hit), {31'h0, exp_h} << r);
    if (fl) flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  initial begin
    int   ng;
    int   nr;
    int   twohot;
    int   pulses;
    int   gq [4];
    logic [1:0]  rv [3];
    logic [15:0] rd [3];
    logic [1:0]  rh [3];

    // Reset state, then a miss and a swapped-operand hit.
    do_reset();
    do_op("or_miss", 0, 2'b01, 8'h0F, 8'hF0, 3, 8'hFF, 1'b0, 1'b0);
    chk("hitc0", 32'(hit_count), 32'h0);
    do_op("or_hit", 1, 2'b01, 8'hF0, 8'h0F, 1, 8'hFF, 1'b1, 1'b0);
    chk("hitc1", 32'(hit_count), 32'h1);

    // Both requesters valid from reset with distinct ANDN keys.
    do_reset();
    req_op = 4'b1111;
    req_a  = 16'hFFFF;
    req_b  = 16'hF00F;
    req_valid = 2'b11;
    ng = 0; nr = 0; twohot = 0;
    for (int c = 0; c < 20; c++) begin
      if (ng == 3) req_valid = 2'b00;
      #1;
      if ($countones(req_ready) > 1) twohot++;
      if (req_ready != 2'b00 && ng < 4) begin
        gq[ng] = (req_ready == 2'b10) ? 1 : 0;
        ng++;
      end
      if (rsp_valid != 2'b00 && nr < 3) begin
        rv[nr] = rsp_valid; rd[nr] = rsp_data; rh[nr] = rsp_hit;
        nr++;
      end
      @(negedge clk);
    end
    chk("rr_twohot", 32'(twohot), 32'h0);
    chk("rr_ngrant", 32'(ng), 32'h3);
    chk("rr_g0", 32'(gq[0]), 32'h0);
    chk("rr_g1", 32'(gq[1]), 32'h1);
    chk("rr_g2", 32'(gq[2]), 32'h0);
    chk("rr_nrsp", 32'(nr), 32'h3);
    chk("rr_r0v", 32'(rv[0]), 32'h1);
    chk("rr_r0d", 32'(rd[0]), 32'h00F0);
    chk("rr_r0h", 32'(rh[0]), 32'h0);
    chk("rr_r1v", 32'(rv[1]), 32'h2);
    chk("rr_r1d", 32'(rd[1]), 32'h0F00);
    chk("rr_r1h", 32'(rh[1]), 32'h0);
    chk("rr_r2v", 32'(rv[2]), 32'h1);
    chk("rr_r2d", 32'(rd[2]), 32'h00F0);
    chk("rr_r2h", 32'(rh[2]), 32'h1);

    // FIFO eviction: five AND misses into four entries.
    do_reset();
    do_op("ev_k1", 0, 2'b00, 8'h01, 8'hFF, 3, 8'h01, 1'b0, 1'b0);
    do_op("ev_k2", 0, 2'b00, 8'h02, 8'hFF, 3, 8'h02, 1'b0, 1'b0);
    do_op("ev_k3", 0, 2'b00, 8'hFF, 8'h03, 3, 8'h03, 1'b0, 1'b0);
    do_op("ev_k4", 1, 2'b00, 8'h04, 8'hFF, 3, 8'h04, 1'b0, 1'b0);
    do_op("ev_k5", 0, 2'b00, 8'h05, 8'hFF, 3, 8'h05, 1'b0, 1'b0);
    do_op("ev_k2hit", 1, 2'b00, 8'hFF, 8'h02, 1, 8'h02, 1'b1, 1'b0);
    do_op("ev_k1miss", 0, 2'b00, 8'h01, 8'hFF, 3, 8'h01, 1'b0, 1'b0);
    do_op("ev_k3hit", 0, 2'b00, 8'h03, 8'hFF, 1, 8'h03, 1'b1, 1'b0);
    do_op("ev_k5hit", 1, 2'b00, 8'h05, 8'hFF, 1, 8'h05, 1'b1, 1'b0);
    chk("ev_hitc", 32'(hit_count), 32'h3);

    // Flush coincident with a miss fill: response delivered, nothing kept.
    do_op("fl_xor", 0, 2'b10, 8'hAA, 8'h55, 3, 8'hFF, 1'b0, 1'b0);
    do_op("fl_or", 1, 2'b01, 8'h12, 8'h34, 3, 8'h36, 1'b0, 1'b1);
    do_op("fl_xor2", 0, 2'b10, 8'h55, 8'hAA, 3, 8'hFF, 1'b0, 1'b0);
    do_op("fl_or2", 1, 2'b01, 8'h34, 8'h12, 3, 8'h36, 1'b0, 1'b0);
    chk("fl_hitc", 32'(hit_count), 32'h3);

    // Reset during EXEC: no response, cache empty, RR back to requester 0.
    req_op[1:0] = 2'b00; req_a[7:0] = 8'h3C; req_b[7:0] = 8'hFF;
    req_valid = 2'b01;
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    reset_n   = 1'b0;
    pulses    = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) reset_n = 1'b1;
      @(negedge clk);
      if (rsp_valid != 2'b00) pulses++;
    end
    chk("mr_pulses", 32'(pulses), 32'h0);
    chk("mr_hitc", 32'(hit_count), 32'h0);
    req_op[3:2] = 2'b01; req_a[15:8] = 8'h01; req_b[15:8] = 8'h02;
    req_valid[1] = 1'b1;
    do_op("mr_xor", 0, 2'b10, 8'hAA, 8'h55, 3, 8'hFF, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
